// File: rtl/cv32e40p_conv_tile_sched_if.sv
// Data-memory request/response bundle between the tile scheduler (master) and memory (slave).
// One request per cycle; reads return later through the rvalid/rdata response channel.
interface cv32e40p_conv_tile_sched_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/cv32e40p_conv_tile_sched.sv
// Tile sequencer for the 2x2-output / 3x3-kernel conv engine: fetches a TILE_DIM x TILE_DIM
// input tile, loads the engine, runs it, applies optional ReLU and writes the 4 results back.
module cv32e40p_conv_tile_sched #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TILE_DIM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          in_addr_i,
  input  logic [ADDR_W-1:0]          in_stride_i,
  input  logic [ADDR_W-1:0]          out_addr_i,
  input  logic                       relu_en_i,
  output logic                       busy_o,
  output logic                       done_o,
  cv32e40p_conv_tile_sched_if.master mem,
  output logic                       tile_we_o,
  output logic [3:0]                 tile_idx_o,
  output logic [DATA_W-1:0]          tile_data_o,
  output logic                       eng_start_o,
  input  logic                       eng_done_i,
  input  logic [4*DATA_W-1:0]        eng_y_i
);

  localparam int unsigned CW = $clog2(TILE_DIM);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StStart, StCalc, StWrReq, StDone
  } state_e;

  state_e            state_q;
  logic [3:0]        k_q;
  logic [CW-1:0]     col_q;
  logic [1:0]        j_q;
  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              relu_q;
  logic [DATA_W-1:0] res_q [4];
  logic              busy_q, done_q, req_q, we_q, eng_start_q;

  // Byte offsets are forced to zero at sampling, so the low address bits are never consumed.
  logic unused_lsbs;
  assign unused_lsbs = ^{in_addr_i[1:0], in_stride_i[1:0], out_addr_i[1:0]};

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v, input logic en);
    return (en && v[DATA_W-1]) ? '0 : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      col_q       <= '0;
      j_q         <= '0;
      row_q       <= '0;
      stride_q    <= '0;
      out_addr_q  <= '0;
      addr_q      <= '0;
      relu_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      eng_start_q <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      done_q      <= 1'b0;
      eng_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            row_q      <= {in_addr_i[ADDR_W-1:2], 2'b00};
            addr_q     <= {in_addr_i[ADDR_W-1:2], 2'b00};
            stride_q   <= {in_stride_i[ADDR_W-1:2], 2'b00};
            out_addr_q <= {out_addr_i[ADDR_W-1:2], 2'b00};
            relu_q     <= relu_en_i;
            k_q        <= '0;
            col_q      <= '0;
            busy_q     <= 1'b1;
            req_q      <= 1'b1;
            we_q       <= 1'b0;
            state_q    <= StRdReq;
          end
        end
        StRdReq: begin
          if (mem.gnt) begin
            req_q   <= 1'b0;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          if (mem.rvalid) begin
            if (k_q == 4'(TILE_DIM * TILE_DIM - 1)) begin
              eng_start_q <= 1'b1;
              state_q     <= StStart;
            end else begin
              k_q   <= k_q + 4'd1;
              req_q <= 1'b1;
              // Row wrap restarts from the row base so the stride is applied exactly once.
              if (col_q == CW'(TILE_DIM - 1)) begin
                col_q  <= '0;
                row_q  <= row_q + stride_q;
                addr_q <= row_q + stride_q;
              end else begin
                col_q  <= col_q + CW'(1);
                addr_q <= addr_q + ADDR_W'(4);
              end
              state_q <= StRdReq;
            end
          end
        end
        StStart: state_q <= StCalc;
        StCalc: begin
          if (eng_done_i) begin
            for (int i = 0; i < 4; i++) res_q[i] <= relu(eng_y_i[i*DATA_W +: DATA_W], relu_q);
            j_q     <= '0;
            addr_q  <= out_addr_q;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= StWrReq;
          end
        end
        StWrReq: begin
          if (mem.gnt) begin
            if (j_q == 2'd3) begin
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              j_q    <= j_q + 2'd1;
              addr_q <= addr_q + ADDR_W'(4);
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign eng_start_o = eng_start_q;
  assign mem.req     = req_q;
  assign mem.we      = we_q;
  assign mem.addr    = addr_q;
  assign mem.wdata   = we_q ? res_q[j_q] : '0;

  // Read data is forwarded to the engine in the same cycle it returns.
  always_comb begin
    tile_we_o   = 1'b0;
    tile_idx_o  = '0;
    tile_data_o = '0;
    if (state_q == StRdWait && mem.rvalid) begin
      tile_we_o   = 1'b1;
      tile_idx_o  = k_q;
      tile_data_o = mem.rdata;
    end
  end

endmodule
